// File: rtl/sim_run_ctrl.sv
// rtl/sim_run_ctrl.sv - difftest run sequencer: DUT reset hold, checker init handshake, stepping, log window, perf pulses, finish code
module sim_run_ctrl #(
    parameter int unsigned RESET_CYCLES = 50,
    parameter int unsigned INIT_TIMEOUT = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] cfg_max_cycles,
    input  logic [63:0] cfg_log_begin,
    input  logic [63:0] cfg_log_end,
    input  logic [31:0] cfg_perf_interval,
    output logic        dut_reset,
    output logic        init_req,
    input  logic        init_ack,
    output logic        step_en,
    input  logic        stop_req,
    output logic        log_enable,
    output logic        perf_dump,
    output logic        perf_clean,
    output logic [63:0] cycle_cnt,
    output logic        finish,
    output logic [1:0]  finish_code
);

    typedef enum logic [2:0] {HOLD, INIT, RUN, FLUSH, DONE} state_t;

    localparam logic [31:0] HOLD_LAST = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] WAIT_LAST = 32'(INIT_TIMEOUT - 1);

    state_t      state;
    logic [31:0] hold_cnt;
    logic [31:0] wait_cnt;
    logic [31:0] perf_cnt;
    logic [63:0] max_q;
    logic [63:0] begin_q;
    logic [63:0] end_q;
    logic [31:0] interval_q;

    // Config seen by the next-cycle logic: live inputs on the edge that
    // latches them (INIT -> RUN), latched copies afterwards.
    logic [63:0] eff_begin;
    logic [63:0] eff_end;
    logic [31:0] eff_int;
    logic [31:0] perf_last;
    logic [31:0] perf_inc;
    logic [63:0] cnt_inc;
    logic        max_hit;
    logic        log_first;
    logic        log_run;
    logic        dump_first;
    logic        dump_run;

    // Next-cycle values for the registered outputs of the RUN state.
    always_comb begin
        eff_begin  = (state == INIT) ? cfg_log_begin     : begin_q;
        eff_end    = (state == INIT) ? cfg_log_end       : end_q;
        eff_int    = (state == INIT) ? cfg_perf_interval : interval_q;
        perf_last  = eff_int - 32'd1;
        perf_inc   = (perf_cnt == perf_last) ? 32'd0 : perf_cnt + 32'd1;
        cnt_inc    = (&cycle_cnt) ? cycle_cnt : cycle_cnt + 64'd1;
        max_hit    = (max_q != 64'd0) && (cycle_cnt == max_q - 64'd1);
        log_first  = (eff_end != 64'd0) && (eff_begin == 64'd0);
        log_run    = (eff_end != 64'd0) && (eff_begin <= cnt_inc) && (cnt_inc < eff_end);
        dump_first = (eff_int == 32'd1);
        dump_run   = (eff_int != 32'd0) && (perf_inc == perf_last);
    end

    // Run sequencer: state, counters, latched config and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= HOLD;
            hold_cnt    <= 32'd0;
            wait_cnt    <= 32'd0;
            perf_cnt    <= 32'd0;
            max_q       <= 64'd0;
            begin_q     <= 64'd0;
            end_q       <= 64'd0;
            interval_q  <= 32'd0;
            dut_reset   <= 1'b1;
            init_req    <= 1'b0;
            step_en     <= 1'b0;
            log_enable  <= 1'b0;
            perf_dump   <= 1'b0;
            perf_clean  <= 1'b0;
            cycle_cnt   <= 64'd0;
            finish      <= 1'b0;
            finish_code <= 2'd0;
        end else begin
            case (state)
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state     <= INIT;
                        dut_reset <= 1'b0;
                        init_req  <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 32'd1;
                    end
                end
                INIT: begin
                    if (init_ack) begin
                        state      <= RUN;
                        init_req   <= 1'b0;
                        step_en    <= 1'b1;
                        max_q      <= cfg_max_cycles;
                        begin_q    <= cfg_log_begin;
                        end_q      <= cfg_log_end;
                        interval_q <= cfg_perf_interval;
                        perf_cnt   <= 32'd0;
                        log_enable <= log_first;
                        perf_dump  <= dump_first;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state       <= DONE;
                        init_req    <= 1'b0;
                        finish      <= 1'b1;
                        finish_code <= 2'd3;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                RUN: begin
                    cycle_cnt <= cnt_inc;
                    if (stop_req || max_hit) begin
                        state       <= FLUSH;
                        step_en     <= 1'b0;
                        log_enable  <= 1'b0;
                        perf_dump   <= 1'b1;
                        perf_clean  <= 1'b0;
                        finish_code <= stop_req ? 2'd1 : 2'd2;
                    end else begin
                        perf_cnt   <= perf_inc;
                        log_enable <= log_run;
                        perf_dump  <= dump_run;
                        perf_clean <= perf_dump;
                    end
                end
                FLUSH: begin
                    state     <= DONE;
                    perf_dump <= 1'b0;
                    finish    <= 1'b1;
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb/tb_sim_run_ctrl.sv - directed self-checking bench for sim_run_ctrl
module tb_sim_run_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] cfg_max_cycles = 64'd0;
    logic [63:0] cfg_log_begin = 64'd0;
    logic [63:0] cfg_log_end = 64'd0;
    logic [31:0] cfg_perf_interval = 32'd0;
    logic        dut_reset;
    logic        init_req;
    logic        init_ack = 1'b0;
    logic        step_en;
    logic        stop_req = 1'b0;
    logic        log_enable;
    logic        perf_dump;
    logic        perf_clean;
    logic [63:0] cycle_cnt;
    logic        finish;
    logic [1:0]  finish_code;

    int tests = 0;
    int fails = 0;

    int          hold_edges;
    int          req_cyc;
    int          steps;
    int          flushd;
    int          overlap;
    int          fin_gap;
    int          last_step;
    logic [1:0]  code;
    logic [63:0] cnt;
    logic [63:0] logm;
    logic [63:0] dumpm;
    logic [63:0] cleanm;

    sim_run_ctrl #(.RESET_CYCLES(4), .INIT_TIMEOUT(5)) dut (
        .clock(clock),
        .reset(reset),
        .cfg_max_cycles(cfg_max_cycles),
        .cfg_log_begin(cfg_log_begin),
        .cfg_log_end(cfg_log_end),
        .cfg_perf_interval(cfg_perf_interval),
        .dut_reset(dut_reset),
        .init_req(init_req),
        .init_ack(init_ack),
        .step_en(step_en),
        .stop_req(stop_req),
        .log_enable(log_enable),
        .perf_dump(perf_dump),
        .perf_clean(perf_clean),
        .cycle_cnt(cycle_cnt),
        .finish(finish),
        .finish_code(finish_code)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete run: reset, release, ack after the third init_req cycle
    // (unless noack), optional stop on step stop_at, optional reset on step abort_at.
    task automatic do_run(input logic [63:0] mx, input logic [63:0] bg, input logic [63:0] en,
                          input logic [31:0] iv, input int stop_at, input int abort_at,
                          input bit noack, input bit chg);
        bit done;
        reset = 1'b0;
        cfg_max_cycles = mx;
        cfg_log_begin = bg;
        cfg_log_end = en;
        cfg_perf_interval = iv;
        init_ack = 1'b0;
        stop_req = 1'b0;
        tick();
        check("reset_ctrl", 64'({dut_reset, init_req, step_en, log_enable, perf_dump,
                                 perf_clean, finish, finish_code}), 64'h100);
        check("reset_cnt", cycle_cnt, 64'd0);
        reset = 1'b1;
        hold_edges = 0; req_cyc = 0; steps = 0; flushd = 0; overlap = 0;
        fin_gap = 0; last_step = 0; code = 2'd0; cnt = 64'd0;
        logm = 64'd0; dumpm = 64'd0; cleanm = 64'd0;
        done = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (!dut_reset && hold_edges == 0) hold_edges = n;
            if (init_req) req_cyc++;
            if (init_req && step_en) overlap++;
            if (step_en) begin
                steps++;
                last_step = n;
                logm[cycle_cnt[5:0]] = log_enable;
                dumpm[cycle_cnt[5:0]] = perf_dump;
                cleanm[cycle_cnt[5:0]] = perf_clean;
            end else if (perf_dump) begin
                flushd++;
            end
            if (finish) begin
                fin_gap = n - last_step;
                code = finish_code;
                cnt = cycle_cnt;
                done = 1'b1;
                break;
            end
            if (abort_at != 0 && steps == abort_at) begin
                reset = 1'b0;
                tick();
                check("abort_state", 64'({dut_reset, step_en, finish, init_req}), 64'h8);
                check("abort_cnt", cycle_cnt, 64'd0);
                done = 1'b1;
                break;
            end
            if (chg && steps == 2) begin
                cfg_max_cycles = 64'd3;
                cfg_perf_interval = 32'd2;
                cfg_log_begin = 64'd0;
                cfg_log_end = 64'd100;
            end
            init_ack = !noack && init_req && req_cyc == 3;
            stop_req = step_en && steps == stop_at;
        end
        if (!done) check("run_timeout", 64'd0, 64'd1);
        init_ack = 1'b0;
        stop_req = 1'b0;
        if (abort_at == 0) begin
            tick();
            tick();
            check("sticky", 64'({finish, step_en, perf_dump, perf_clean, finish_code}), 64'({4'b1000, code}));
        end
    endtask

    initial begin
        // max=10, no stop
        do_run(64'd10, 64'd0, 64'd0, 32'd0, 0, 0, 1'b0, 1'b0);
        check("t1_hold", 64'(hold_edges), 64'd4);
        check("t1_req", 64'(req_cyc), 64'd3);
        check("t1_overlap", 64'(overlap), 64'd0);
        check("t1_steps", 64'(steps), 64'd10);
        check("t1_code", 64'(code), 64'd2);
        check("t1_cnt", cnt, 64'd10);
        check("t1_flush", 64'(flushd), 64'd1);
        check("t1_gap", 64'(fin_gap), 64'd2);
        check("t1_dump", dumpm, 64'd0);

        // unlimited, stop on step 7
        do_run(64'd0, 64'd0, 64'd0, 32'd0, 7, 0, 1'b0, 1'b0);
        check("t2_steps", 64'(steps), 64'd7);
        check("t2_code", 64'(code), 64'd1);
        check("t2_cnt", cnt, 64'd7);
        check("t2_gap", 64'(fin_gap), 64'd2);

        // stop and max in the same cycle
        do_run(64'd7, 64'd0, 64'd0, 32'd0, 7, 0, 1'b0, 1'b0);
        check("t3_steps", 64'(steps), 64'd7);
        check("t3_code", 64'(code), 64'd1);

        // init timeout
        do_run(64'd10, 64'd0, 64'd0, 32'd0, 0, 0, 1'b1, 1'b0);
        check("t4_req", 64'(req_cyc), 64'd5);
        check("t4_steps", 64'(steps), 64'd0);
        check("t4_code", 64'(code), 64'd3);
        check("t4_cnt", cnt, 64'd0);

        // log window [3,6)
        do_run(64'd10, 64'd3, 64'd6, 32'd0, 0, 0, 1'b0, 1'b0);
        check("t5_log", logm, 64'h38);
        check("t5_steps", 64'(steps), 64'd10);

        // end=0 disables logging
        do_run(64'd10, 64'd3, 64'd0, 32'd0, 0, 0, 1'b0, 1'b0);
        check("t6_log", logm, 64'd0);

        // begin >= end never enables
        do_run(64'd10, 64'd6, 64'd4, 32'd0, 0, 0, 1'b0, 1'b0);
        check("t6b_log", logm, 64'd0);

        // perf interval 4 with cfg changes mid-run
        do_run(64'd10, 64'd0, 64'd0, 32'd4, 0, 0, 1'b0, 1'b1);
        check("t7_dump", dumpm, 64'h88);
        check("t7_clean", cleanm, 64'h110);
        check("t7_steps", 64'(steps), 64'd10);
        check("t7_flush", 64'(flushd), 64'd1);
        check("t7_log", logm, 64'd0);

        // perf interval 1
        do_run(64'd5, 64'd0, 64'd0, 32'd1, 0, 0, 1'b0, 1'b0);
        check("t8_dump", dumpm, 64'h1f);
        check("t8_clean", cleanm, 64'h1e);
        check("t8_flush", 64'(flushd), 64'd1);

        // max=1 boundary
        do_run(64'd1, 64'd0, 64'd0, 32'd0, 0, 0, 1'b0, 1'b0);
        check("t9_steps", 64'(steps), 64'd1);
        check("t9_code", 64'(code), 64'd2);

        // reset mid-run at step 5, then the full sequence again
        do_run(64'd0, 64'd0, 64'd0, 32'd0, 0, 5, 1'b0, 1'b0);
        check("t10_steps", 64'(steps), 64'd5);
        do_run(64'd10, 64'd0, 64'd0, 32'd0, 0, 0, 1'b0, 1'b0);
        check("t10_hold", 64'(hold_edges), 64'd4);
        check("t10_steps2", 64'(steps), 64'd10);
        check("t10_code", 64'(code), 64'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sim_run_ctrl.md
# sim_run_ctrl

Simulation run controller for the difftest VCS/Verilator harness. It sits between the testbench top and `SimTop` plus the DPI checker glue, and sequences a run:
- holds the DUT in reset for a fixed number of cycles;
- performs a handshaked checker init;
- issues one step per cycle while counting cycles;
- derives the log window and periodic perf dump/clean pulses;
- terminates on checker stop, max-cycle limit or init timeout, with a sticky finish code.

## Interface
Parameters:
- `RESET_CYCLES`, 50: cycles `dut_reset` is held high after controller reset (≥1).
- `INIT_TIMEOUT`, 1000: max cycles `init_req` may wait for `init_ack` (≥1).

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  synchronous, active-low.
- `cfg_max_cycles`  in  64  run-cycle limit; 0 = unlimited.
- `cfg_log_begin`  in  64  first run cycle with logging enabled.
- `cfg_log_end`  in  64  first run cycle with logging disabled; 0 = logging off.
- `cfg_perf_interval`  in  32  perf dump period in run cycles; 0 = periodic dumps off.
- `dut_reset`  out  1  active-high reset to `SimTop`.
- `init_req`  out  1  request checker init; held until acked.
- `init_ack`  in  1  init complete.
- `step_en`  out  1  invoke checker step this cycle.
- `stop_req`  in  1  checker reports stop/error; sampled only when `step_en`=1.
- `log_enable`  out  1  to `io_logCtrl` gating.
- `perf_dump`  out  1  one-cycle pulse.
- `perf_clean`  out  1  one-cycle pulse.
- `cycle_cnt`  out  64  completed step count.
- `finish`  out  1  sticky run-complete.
- `finish_code`  out  2  0 none, 1 checker stop, 2 max cycles, 3 init timeout.

## Operation
- FSM states: `HOLD` → `INIT` → `RUN` → `FLUSH` → `DONE`.
- `reset`=0 forces `HOLD` and clears all counters. Output reset values: `dut_reset`=1, all other outputs 0.
- `HOLD`:
  - `dut_reset`=1; the hold counter counts `RESET_CYCLES`.
  - On the last hold cycle, go to `INIT`.
- `INIT`:
  - `dut_reset`=0, `init_req`=1.
  - When `init_ack`=1, go to `RUN`, and latch all `cfg_*` inputs into internal registers. Later `cfg_*` changes are ignored until the next reset.
  - If `INIT_TIMEOUT` cycles elapse without `init_ack`, go to `DONE` with code 3.
- `RUN`:
  - `step_en`=1 every cycle.
  - `cycle_cnt` increments at the end of each `RUN` cycle; its value is 0 during the first `RUN` cycle.
  - `stop_req`=1 → `FLUSH`, code 1.
  - Max-cycle limit: if latched max ≠ 0 and `cycle_cnt` == max−1 → `FLUSH`, code 2. Exactly max steps are issued.
  - If both stop and max occur in the same cycle, code 1 takes priority.
  - `cycle_cnt` saturates at 2^64−1 (no wrap).
- `FLUSH`: one cycle; `step_en`=0, `perf_dump`=1 (final dump); then `DONE`.
- `DONE`:
  - `finish`=1, `finish_code` stable; all pulses 0; `dut_reset`=0.
  - Stays until reset.
- `log_enable`:
  - Registered. During `RUN` it is 1 iff latched end ≠ 0 and begin ≤ `cycle_cnt` < end, with all compares unsigned 64-bit.
  - It is 0 in all other states.
  - begin ≥ end → never enabled.
- Perf:
  - With latched interval N ≠ 0, a perf counter runs in `RUN` and wraps at N−1.
  - `perf_dump` pulses in the `RUN` cycle where the counter == N−1.
  - `perf_clean` pulses the next cycle, unless that cycle is `FLUSH` (no clean in `FLUSH`).
  - N=1 → `perf_dump` every `RUN` cycle, and `perf_clean` every `RUN` cycle after the first.

## Timing
- `reset` is released at edge 0. `dut_reset` falls after exactly `RESET_CYCLES` edges; `init_req` rises in the same cycle.
- `init_ack` sampled high at edge k → first `step_en` in cycle k+1. `init_req` drops in the same cycle `step_en` rises.
- `stop_req` sampled with `step_en` at edge k → `step_en`=0 from cycle k+1 (`FLUSH`); `finish`=1 from cycle k+2.
- `finish_code` is registered together with the transition out of `RUN` or `INIT`, so it is valid no later than `finish`.
- `reset`=0 mid-run (any state) → next cycle equals the post-reset state; sticky `finish` clears.

## Test plan
- `RESET_CYCLES`=4, ack 2 cycles after `init_req`, max=10, no stop → exactly 10 `step_en` cycles, one `FLUSH` dump, `finish`=1, code 2, `cycle_cnt`=10.
- Max=0, `stop_req` at the 7th step → 7 steps, code 1, `cycle_cnt`=7. Variant with max=7 and stop on step 7 → code 1.
- `INIT_TIMEOUT`=5, `init_ack` never asserted → `init_req` high for 5 cycles, no `step_en`, code 3.
- begin=3, end=6, max=10 → `log_enable` high only while `cycle_cnt` ∈ {3,4,5}. Variant end=0 → never high.
- interval=4, max=10 → `perf_dump` at `cycle_cnt` 3 and 7 plus the `FLUSH` dump; `perf_clean` at 4 and 8. Changing `cfg_*` during `RUN` has no effect.
- `reset`=0 asserted at step 5 → `dut_reset`=1, `cycle_cnt`=0, `finish`=0 next cycle; full sequence repeats after release.
